// File: rtl/div_share_arbiter.sv
//------------------------------------------------------------------------------
// div_share_arbiter: two requesters share one restoring divider with a
// round-robin grant. Rev 1.0
//------------------------------------------------------------------------------
`default_nettype none

module div_share_arbiter #(
  parameter int DIVIDEND_W = 8,
  parameter int DIVISOR_W  = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid0,
  input  logic                  req_valid1,
  output logic                  req_ready0,
  output logic                  req_ready1,
  input  logic [DIVIDEND_W-1:0] dividend0,
  input  logic [DIVIDEND_W-1:0] dividend1,
  input  logic [DIVISOR_W-1:0]  divisor0,
  input  logic [DIVISOR_W-1:0]  divisor1,
  output logic                  rsp_valid0,
  output logic                  rsp_valid1,
  input  logic                  rsp_ready0,
  input  logic                  rsp_ready1,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero,
  output logic                  busy
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DIVIDEND_W - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state;
  state_t                 state_next;
  logic [CNT_W-1:0]       step_cnt;
  logic                   owner;
  logic                   last_grant;
  logic [DIVIDEND_W-1:0]  dvd;
  logic [DIVISOR_W-1:0]   dvs;

  logic                   grant0;
  logic                   grant1;
  logic                   handshake;
  logic [DIVIDEND_W-1:0]  sel_dividend;
  logic [DIVISOR_W-1:0]   sel_divisor;
  logic                   owner_taken;
  logic [DIVISOR_W:0]     partial;
  logic                   take;
  logic [DIVISOR_W-1:0]   diff;

  // Round-robin: on contention the port not granted last wins.
  always_comb begin
    grant0       = req_valid0 && (!req_valid1 || last_grant);
    grant1       = req_valid1 && (!req_valid0 || !last_grant);
    req_ready0   = (state == IDLE) && !reset && grant0;
    req_ready1   = (state == IDLE) && !reset && grant1;
    handshake    = req_ready0 || req_ready1;
    sel_dividend = req_ready1 ? dividend1 : dividend0;
    sel_divisor  = req_ready1 ? divisor1 : divisor0;
    owner_taken  = owner ? rsp_ready1 : rsp_ready0;
    busy         = (state != IDLE);
    rsp_valid0   = (state == DONE) && !owner;
    rsp_valid1   = (state == DONE) && owner;
  end

  // One restoring step; the low bits of the subtraction are exact because
  // the true difference always fits below the divisor.
  always_comb begin
    partial = {remainder, dvd[DIVIDEND_W-1]};
    take    = (partial >= {1'b0, dvs});
    diff    = partial[DIVISOR_W-1:0] - dvs;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (handshake) begin
          state_next = (sel_divisor == '0) ? DONE : RUN;
        end
      end
      RUN: begin
        if (step_cnt == LAST_STEP) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (owner_taken) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      step_cnt    <= '0;
      owner       <= 1'b0;
      last_grant  <= 1'b1;
      dvd         <= '0;
      dvs         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (handshake) begin
            owner      <= req_ready1;
            last_grant <= req_ready1;
            dvd        <= sel_dividend;
            dvs        <= sel_divisor;
            step_cnt   <= '0;
            if (sel_divisor == '0) begin
              quotient    <= '1;
              remainder   <= sel_dividend[DIVISOR_W-1:0];
              div_by_zero <= 1'b1;
            end else begin
              quotient    <= '0;
              remainder   <= '0;
              div_by_zero <= 1'b0;
            end
          end
        end
        RUN: begin
          step_cnt  <= step_cnt + 1'b1;
          dvd       <= {dvd[DIVIDEND_W-2:0], 1'b0};
          quotient  <= {quotient[DIVIDEND_W-2:0], take};
          remainder <= take ? diff : partial[DIVISOR_W-1:0];
        end
        default: ;
      endcase
    end
  end

endmodule

`default_nettype wire
